// File: rtl/scratchpad_pkg.sv
// Shared types and helpers for the scratchpad arbiter.
package scratchpad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } sp_state_e;

  localparam logic [1:0] LEN_BYTE   = 2'b00;
  localparam logic [1:0] LEN_HALF   = 2'b01;
  localparam logic [1:0] LEN_WORD   = 2'b10;
  localparam logic [1:0] LEN_DOUBLE = 2'b11;

  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [1:0]  len;
    logic [63:0] wdata;
  } sp_req_t;

  // Access size in bytes, widened so range math cannot wrap.
  function automatic logic [64:0] len_bytes(input logic [1:0] len);
    return 65'd1 << len;
  endfunction

endpackage

// File: rtl/scratchpad_rr_arb.sv
// Two-way round-robin grant: the requester at ptr wins ties.
module scratchpad_rr_arb (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot grant, pointer side first.
  always_comb begin
    grant = 2'b00;
    if (!ptr) begin
      if (valid[0])      grant = 2'b01;
      else if (valid[1]) grant = 2'b10;
    end else begin
      if (valid[1])      grant = 2'b10;
      else if (valid[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/scratchpad_arbiter.sv
// Arbitrates two requesters onto one scratchpad port, one access at a time,
// with range/alignment checking before the scratchpad is touched.
module scratchpad_arbiter
  import scratchpad_pkg::*;
#(
  parameter int CHUNK_SIZE      = 4,
  parameter int NUM_CHUNKS      = 16,
  parameter int SCRATCHPAD_BASE = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [1:0]   req_write,
  input  logic [127:0] req_addr,
  input  logic [3:0]   req_len,
  input  logic [127:0] req_wdata,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [63:0]  rsp_rdata,
  output logic         rsp_err,
  output logic         sp_en,
  output logic         sp_write,
  output logic [63:0]  sp_addr,
  output logic [1:0]   sp_len,
  output logic [63:0]  sp_wdata,
  input  logic [63:0]  sp_rdata
);

  localparam logic [64:0] SP_LO = 65'(SCRATCHPAD_BASE);
  localparam logic [64:0] SP_HI = 65'(SCRATCHPAD_BASE) + 65'(CHUNK_SIZE) * 65'(NUM_CHUNKS);

  sp_state_e                 state;
  logic                      ptr;
  logic [1:0]                gnt_q;
  sp_req_t                   req_q;
  logic [63:0]               rdata_q;
  logic                      err_q;

  sp_req_t [NUM_REQ-1:0]     reqs;
  sp_req_t                   sel;
  logic [1:0]                grant;
  logic                      legal;
  logic [64:0]               addr_x;
  logic [64:0]               nbytes;
  logic                      rsp_hs;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_req
      assign reqs[g] = '{write: req_write[g],
                         addr:  req_addr[64*g +: 64],
                         len:   req_len[2*g +: 2],
                         wdata: req_wdata[64*g +: 64]};
    end
  endgenerate

  scratchpad_rr_arb u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Granted request fields and their legality, all range math at 65 bits.
  always_comb begin
    sel    = grant[1] ? reqs[1] : reqs[0];
    addr_x = {1'b0, sel.addr};
    nbytes = len_bytes(sel.len);
    legal  = (addr_x >= SP_LO) && ((addr_x + nbytes) <= SP_HI) &&
             ((addr_x & (nbytes - 65'd1)) == 65'd0);
  end

  // Ready is masked by rst_n so it reads 0 throughout reset.
  assign req_ready = (rst_n && state == IDLE) ? grant : 2'b00;
  assign rsp_valid = (state == RESP) ? gnt_q : 2'b00;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rsp_hs    = |(rsp_valid & rsp_ready);

  // Scratchpad port straight from the latched request; state decodes the strobe.
  assign sp_en    = (state == ACCESS);
  assign sp_write = req_q.write;
  assign sp_addr  = req_q.addr;
  assign sp_len   = req_q.len;
  assign sp_wdata = req_q.wdata;

  // Transaction FSM: grant, optional scratchpad access, response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      gnt_q   <= 2'b00;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            gnt_q   <= grant;
            req_q   <= sel;
            rdata_q <= '0;
            err_q   <= ~legal;
            state   <= legal ? ACCESS : RESP;
          end
        end
        ACCESS:  state <= CAPTURE;
        CAPTURE: begin
          rdata_q <= req_q.write ? 64'd0 : sp_rdata;
          state   <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            ptr   <= ~gnt_q[1];
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Directed bench for scratchpad_arbiter with a byte-array scratchpad model.
module tb_scratchpad_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [1:0]   req_write = '0;
  logic [127:0] req_addr = '0;
  logic [3:0]   req_len = '0;
  logic [127:0] req_wdata = '0;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = '0;
  logic [63:0]  rsp_rdata;
  logic         rsp_err;
  logic         sp_en;
  logic         sp_write;
  logic [63:0]  sp_addr;
  logic [1:0]   sp_len;
  logic [63:0]  sp_wdata;
  logic [63:0]  sp_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sp_cnt = 0;
  int t0, spc0;
  logic [7:0] mem [0:255];

  scratchpad_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .sp_en(sp_en), .sp_write(sp_write), .sp_addr(sp_addr),
    .sp_len(sp_len), .sp_wdata(sp_wdata), .sp_rdata(sp_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (sp_en) sp_cnt <= sp_cnt + 1;

  function automatic logic [63:0] mem_rd(input logic [63:0] a, input logic [1:0] l);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < (1 << l); b++) v[8*b +: 8] = mem[8'(a[7:0] + 8'(b))];
    return v;
  endfunction

  // Scratchpad model: read data appears the cycle after sp_en.
  always @(posedge clk) begin
    if (sp_en) begin
      if (sp_write) begin
        for (int b = 0; b < (1 << sp_len); b++) mem[8'(sp_addr[7:0] + 8'(b))] <= sp_wdata[8*b +: 8];
      end else begin
        sp_rdata <= mem_rd(sp_addr, sp_len);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int idx, input bit wr, input logic [63:0] a,
                       input logic [1:0] l, input logic [63:0] wd);
    req_valid[idx]          = 1'b1;
    req_write[idx]          = wr;
    req_addr[64*idx +: 64]  = a;
    req_len[2*idx +: 2]     = l;
    req_wdata[64*idx +: 64] = wd;
  endtask

  // Waits (bounded) for a grant, checks it went to idx, records accept cycle.
  task automatic wait_grant(input int idx);
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req_ready != 2'b00) break;
      @(negedge clk);
    end
    check($sformatf("grant r%0d", idx), 64'(req_ready), 64'(2'b01 << idx));
    t0   = cyc;
    spc0 = sp_cnt;
    @(negedge clk);
    req_valid[idx] = 1'b0;
  endtask

  // Follows the granted transaction through response and handshake.
  task automatic finish_rsp(input int idx, input bit exp_err, input logic [63:0] exp_rd,
                            input int exp_lat, input int hold);
    bit found;
    logic [63:0] rd0;
    found = 1'b0;
    #1;
    check("sp_en at T+1", 64'(sp_en), 64'(!exp_err));
    for (int n = 0; n < 10; n++) begin
      if (rsp_valid[idx]) begin found = 1'b1; break; end
      @(negedge clk);
      #1;
    end
    check("rsp_valid seen", 64'(found), 64'd1);
    if (!found) return;
    check("rsp latency", 64'(cyc - t0), 64'(exp_lat));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("sp_en count", 64'(sp_cnt - spc0), 64'(!exp_err));
    check("req_ready in RESP", 64'(req_ready), 64'd0);
    rd0 = rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      #1;
      check("hold rsp_valid", 64'(rsp_valid), 64'(2'b01 << idx));
      check("hold rsp_rdata", rsp_rdata, rd0);
      check("hold req_ready", 64'(req_ready), 64'd0);
      check("hold sp_en", 64'(sp_cnt - spc0), 64'(!exp_err));
    end
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    rsp_ready[idx] = 1'b0;
    #1;
    check("rsp_valid after handshake", 64'(rsp_valid[idx]), 64'd0);
  endtask

  task automatic xact(input int idx, input bit wr, input logic [63:0] a, input logic [1:0] l,
                      input logic [63:0] wd, input bit exp_err, input logic [63:0] exp_rd,
                      input int hold);
    @(negedge clk);
    drive(idx, wr, a, l, wd);
    wait_grant(idx);
    finish_rsp(idx, exp_err, exp_rd, exp_err ? 1 : 3, hold);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset: outputs zero even with both requesters valid.
    drive(0, 1'b1, 64'd16, 2'b10, 64'h55);
    drive(1, 1'b0, 64'd20, 2'b10, 64'h0);
    #12;
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst sp_en", 64'(sp_en), 64'd0);
    check("rst sp_addr", sp_addr, 64'd0);
    check("rst rsp_rdata", rsp_rdata, 64'd0);
    check("rst rsp_err", 64'(rsp_err), 64'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Contention twice: service order 0,1,0,1.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      drive(0, 1'b0, 64'd24, 2'b10, 64'd0);
      drive(1, 1'b0, 64'd32, 2'b10, 64'd0);
      wait_grant(0);
      finish_rsp(0, 1'b0, 64'd0, 3, 0);
      wait_grant(1);
      finish_rsp(1, 1'b0, 64'd0, 3, 0);
    end

    // Write then read back a word.
    xact(0, 1'b1, 64'd16, 2'b10, 64'hDEADBEEF, 1'b0, 64'd0, 0);
    xact(0, 1'b0, 64'd16, 2'b10, 64'd0, 1'b0, 64'hDEADBEEF, 0);

    // Out of range and misaligned.
    xact(0, 1'b0, 64'd80, 2'b00, 64'd0, 1'b1, 64'd0, 0);
    xact(0, 1'b0, 64'd78, 2'b10, 64'd0, 1'b1, 64'd0, 0);
    xact(0, 1'b0, 64'd12, 2'b10, 64'd0, 1'b1, 64'd0, 0);
    xact(0, 1'b0, 64'd18, 2'b10, 64'd0, 1'b1, 64'd0, 0);
    xact(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 2'b11, 64'd1, 1'b1, 64'd0, 0);

    // Last double in range is legal.
    xact(0, 1'b1, 64'd72, 2'b11, 64'h0123456789ABCDEF, 1'b0, 64'd0, 0);
    xact(0, 1'b0, 64'd72, 2'b11, 64'd0, 1'b0, 64'h0123456789ABCDEF, 0);

    // Backpressure hold for 5 cycles; pointer then sits at 1.
    xact(0, 1'b0, 64'd16, 2'b10, 64'd0, 1'b0, 64'hDEADBEEF, 5);

    // Reset during ACCESS of a requester-1 read.
    @(negedge clk);
    drive(1, 1'b0, 64'd20, 2'b10, 64'd0);
    wait_grant(1);
    #1;
    check("sp_en in ACCESS", 64'(sp_en), 64'd1);
    req_valid[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst mid sp_en", 64'(sp_en), 64'd0);
    check("rst mid req_ready", 64'(req_ready), 64'd0);
    check("rst mid rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    spc0 = sp_cnt;
    repeat (4) @(negedge clk);
    #1;
    check("abandoned no rsp", 64'(rsp_valid), 64'd0);
    check("abandoned no sp_en", 64'(sp_cnt - spc0), 64'd0);

    // Pointer back at 0 after reset.
    @(negedge clk);
    drive(0, 1'b0, 64'd16, 2'b10, 64'd0);
    drive(1, 1'b0, 64'd72, 2'b11, 64'd0);
    wait_grant(0);
    finish_rsp(0, 1'b0, 64'hDEADBEEF, 3, 0);
    wait_grant(1);
    finish_rsp(1, 1'b0, 64'h0123456789ABCDEF, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scratchpad_arbiter.md
SCRATCHPAD_ARBITER -- requirements
Module: scratchpad_arbiter

Interface
REQ-001 The block SHALL have parameter CHUNK_SIZE, default 4, meaning bytes per scratchpad chunk.
REQ-002 The block SHALL have parameter NUM_CHUNKS, default 16, meaning number of chunks.
REQ-003 The block SHALL have parameter SCRATCHPAD_BASE, default 16, meaning first valid byte address.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester request accept
- req_write  in  2  per-requester write flag
- req_addr  in  128  per-requester byte address, requester i at [64i+63:64i]
- req_len  in  4  per-requester length code; 00 byte, 01 half, 10 word, 11 double
- req_wdata  in  128  per-requester write data
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response accept
- rsp_rdata  out  64  read data, shared by both requesters
- rsp_err  out  1  range/alignment error flag, shared
- sp_en, sp_write  out  1 each  scratchpad enable and write
- sp_addr  out  64  scratchpad address
- sp_len  out  2  scratchpad length
- sp_wdata  out  64  scratchpad write data
- sp_rdata  in  64  scratchpad read data, valid the cycle after sp_en

Function
REQ-006 The FSM SHALL have the states IDLE, ACCESS, CAPTURE and RESP.
REQ-007 In IDLE, if any req_valid is set, the block SHALL grant one requester, assert only that requester's req_ready in the same cycle, latch its fields, and leave IDLE.
REQ-008 Arbitration SHALL be round-robin: the priority pointer starts at 0 and, on each RESP handshake, moves to the requester that was not just served.
REQ-009 A request SHALL be legal iff addr >= SCRATCHPAD_BASE, addr+2^len <= SCRATCHPAD_BASE+CHUNK_SIZE*NUM_CHUNKS, and addr is aligned to 2^len, all computed at 65-bit width.
REQ-010 For a legal request the FSM SHALL go IDLE->ACCESS.
REQ-011 For an illegal request the FSM SHALL go IDLE->RESP with rsp_err=1 and rsp_rdata=0, and sp_en SHALL never assert.
REQ-012 In ACCESS, sp_en SHALL be 1 for exactly one cycle, with sp_write/sp_addr/sp_len/sp_wdata taken from the latched request.
REQ-013 sp_en SHALL be 0 in every state other than ACCESS.
REQ-014 In CAPTURE, the block SHALL register sp_rdata for reads (0 for writes), then go to RESP.
REQ-015 In RESP, the granted requester's rsp_valid SHALL be held with stable data until rsp_ready; on the handshake the FSM SHALL return to IDLE.
REQ-016 Legal-request latency: accept at cycle T, sp_en at T+1, rsp_valid earliest at T+3.
REQ-017 Illegal-request latency: rsp_valid earliest at T+1.
REQ-018 Only one request SHALL be outstanding; req_ready SHALL be 0 outside IDLE.
REQ-019 When both requesters are valid in the same cycle, the requester at the pointer SHALL win.
REQ-020 The losing requester's request SHALL remain pending untouched.
REQ-021 The block SHALL issue a new IDLE grant no earlier than the cycle after the RESP handshake.

Reset
REQ-022 While rst_n=0, the state SHALL be IDLE, the pointer 0, and all outputs 0, asynchronously.
REQ-023 Reset asserted mid-operation SHALL abandon the transaction with no response.
REQ-024 Reset asserted mid-operation SHALL drop sp_en immediately.

Structure
REQ-025 Package scratchpad_pkg SHALL hold the FSM state enum, the len encoding constants, and a function returning 2^len bytes.
REQ-026 Round-robin grant logic SHALL be sub-module scratchpad_rr_arb: inputs valid[1:0], ptr; output one-hot grant.

Verification
REQ-027 Bench: requester 0 writes addr 16, len 10, data 0xDEADBEEF, then reads addr 16, len 10 -> sp_en single-cycle each, read rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at T+3.
REQ-028 Bench: both requesters valid at once after reset -> requester 0 is served first and requester 1 second; repeated contention alternates 0,1,0,1.
REQ-029 Bench: read addr 80 len 00, read addr 78 len 10, and read addr 12 -> rsp_err=1, rsp_rdata=0, sp_en never high, rsp_valid at T+1.
REQ-030 Bench: read addr 18 len 10 (misaligned) -> rsp_err=1; read addr 72 len 11 -> legal, rsp_err=0.
REQ-031 Bench: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, both req_ready=0, no further sp_en.
REQ-032 Bench: assert rst_n=0 in ACCESS -> sp_en=0 in the same cycle; after release, state IDLE and pointer 0, and the first grant goes to requester 0.
